// File: rtl/mul_cell_sequencer_pkg.sv
// Shared types, constants and result-combining arithmetic for the multiplier-cell sequencer.
package mul_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE1 = 3'd1,
        WAIT1  = 3'd2,
        ISSUE2 = 3'd3,
        WAIT2  = 3'd4,
        RESP   = 3'd5
    } state_t;

    localparam logic OP_MUL    = 1'b0;
    localparam logic OP_MULXUU = 1'b1;
    localparam int   CELL_LAT  = 1;

    // mid carries into bits 33:32 when both cross products are near full scale.
    function automatic logic [31:0] mul_combine(
        input logic [31:0] p1,
        input logic [31:0] p2,
        input logic [31:0] p3,
        input logic [31:0] hh,
        input logic        op
    );
        logic [33:0] mid;
        mid = 34'(p2) + 34'(p3) + 34'(p1[31:16]);
        if (op == OP_MUL)
            return {mid[15:0], p1[15:0]};
        else
            return hh + 32'(mid[33:16]);
    endfunction

endpackage

// File: rtl/mul_cell_sequencer_if.sv
// Requester, response and multiplier-cell signals of the sequencer; master is the sequencer side.
interface mul_cell_sequencer_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_op;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_id;
    logic [31:0] resp_data;
    logic        busy;
    logic [31:0] cell_src1;
    logic [31:0] cell_src2;
    logic        cell_en;
    logic [31:0] cell_p1;
    logic [31:0] cell_p2;
    logic [31:0] cell_p3;

    modport master (
        input  req_valid, req_op, req_a, req_b, resp_ready, cell_p1, cell_p2, cell_p3,
        output req_ready, resp_valid, resp_id, resp_data, busy, cell_src1, cell_src2, cell_en
    );

    modport slave (
        output req_valid, req_op, req_a, req_b, resp_ready, cell_p1, cell_p2, cell_p3,
        input  req_ready, resp_valid, resp_id, resp_data, busy, cell_src1, cell_src2, cell_en
    );
endinterface

// File: rtl/mul_cell_sequencer_rr_arb2.sv
// Two-way round-robin arbiter; combinational grant, last winner updated on advance.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);
    logic last_grant;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            last_grant <= 1'b1;
        else if (advance)
            last_grant <= gnt[1];
    end
endmodule

// File: rtl/mul_cell_sequencer.sv
// Shares one 16x16 partial-product cell between two requesters: MUL responds 3 cycles after accept,
// MULXUU after 5; requests are accepted only in IDLE and the response holds until resp_ready.
module mul_cell_sequencer #(
    parameter int CELL_LAT = mul_seq_pkg::CELL_LAT
) (
    input  logic                 clk,
    input  logic                 reset,
    mul_cell_sequencer_if.master bus
);
    import mul_seq_pkg::*;

    if (CELL_LAT != 1) begin : g_bad_cell_lat
        $error("mul_cell_sequencer: only CELL_LAT == 1 is supported");
    end

    state_t      state, state_nxt;
    logic [1:0]  gnt;
    logic        accept;
    logic [31:0] a_q, b_q, p1_q, p2_q, p3_q, hh_q;
    logic        op_q, id_q;
    logic [31:0] src1, src2;
    logic        en;

    rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (bus.req_valid),
        .advance (accept),
        .gnt     (gnt)
    );

    always_comb begin
        state_nxt = state;
        en        = 1'b0;
        src1      = '0;
        src2      = '0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (|gnt && !reset) begin
                    accept    = 1'b1;
                    state_nxt = ISSUE1;
                end
            end
            ISSUE1: begin
                en        = 1'b1;
                src1      = a_q;
                src2      = b_q;
                state_nxt = WAIT1;
            end
            WAIT1:   state_nxt = (op_q == OP_MULXUU) ? ISSUE2 : RESP;
            ISSUE2: begin
                en        = 1'b1;
                src1      = {16'h0, a_q[31:16]};
                src2      = {16'h0, b_q[31:16]};
                state_nxt = WAIT2;
            end
            WAIT2:   state_nxt = RESP;
            RESP:    if (bus.resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= 1'b0;
            id_q <= 1'b0;
            p1_q <= '0;
            p2_q <= '0;
            p3_q <= '0;
            hh_q <= '0;
        end else begin
            if (accept) begin
                a_q  <= gnt[1] ? bus.req_a[63:32] : bus.req_a[31:0];
                b_q  <= gnt[1] ? bus.req_b[63:32] : bus.req_b[31:0];
                op_q <= gnt[1] ? bus.req_op[1] : bus.req_op[0];
                id_q <= gnt[1];
            end
            if (state == WAIT1) begin
                p1_q <= bus.cell_p1;
                p2_q <= bus.cell_p2;
                p3_q <= bus.cell_p3;
            end
            // Second pass feeds only the high halves, so p1 holds a_hi*b_hi.
            if (state == WAIT2)
                hh_q <= bus.cell_p1;
        end
    end

    assign bus.req_ready  = accept ? gnt : 2'b00;
    assign bus.busy       = (state != IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_id    = (state == RESP) ? id_q : 1'b0;
    assign bus.resp_data  = (state == RESP) ? mul_combine(p1_q, p2_q, p3_q, hh_q, op_q) : 32'h0;
    assign bus.cell_src1  = src1;
    assign bus.cell_src2  = src2;
    assign bus.cell_en    = en;

    a_ready_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(bus.req_ready));
    a_en_spaced:    assert property (@(posedge clk) disable iff (reset) bus.cell_en |=> !bus.cell_en);
endmodule

// File: tb/tb_mul_cell_sequencer.sv
// Directed and randomized bench for mul_cell_sequencer against a 64-bit arithmetic reference.
module tb_mul_cell_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mul_cell_sequencer_if bus ();

    mul_cell_sequencer #(.CELL_LAT(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural multiplier cell: one-cycle registered partial products, held while disabled.
    logic [31:0] cp1 = '0, cp2 = '0, cp3 = '0;
    always_ff @(posedge clk) begin
        if (bus.cell_en) begin
            cp1 <= 32'(bus.cell_src1[15:0]) * 32'(bus.cell_src2[15:0]);
            cp2 <= 32'(bus.cell_src1[15:0]) * 32'(bus.cell_src2[31:16]);
            cp3 <= 32'(bus.cell_src1[31:16]) * 32'(bus.cell_src2[15:0]);
        end
    end
    assign bus.cell_p1 = cp1;
    assign bus.cell_p2 = cp2;
    assign bus.cell_p3 = cp3;

    int vectors = 0;
    int miscompares = 0;
    int last = 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        return op ? p[63:32] : p[31:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_resp_valid"}, bus.resp_valid, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_cell_en"}, bus.cell_en, 0);
        chk({tag, "_req_ready"}, bus.req_ready, 0);
        chk({tag, "_resp_data"}, bus.resp_data, 0);
        chk({tag, "_cell_src1"}, bus.cell_src1, 0);
    endtask

    // One transaction from an IDLE cycle through the response handshake.
    task automatic serve(input logic [1:0] vm, input logic [1:0] ops,
                         input logic [31:0] a0, input logic [31:0] b0,
                         input logic [31:0] a1, input logic [31:0] b1,
                         input int hold, input bit keep);
        int w, lat;
        logic eop;
        logic [31:0] exp_d;
        logic [15:0] en_hist;
        bus.req_valid = vm;
        bus.req_op    = ops;
        bus.req_a     = {a1, a0};
        bus.req_b     = {b1, b0};
        #1;
        w = (vm == 2'b11) ? ((last == 1) ? 0 : 1) : (vm[1] ? 1 : 0);
        chk("req_ready_grant", bus.req_ready, 2'b01 << w);
        last  = w;
        eop   = ops[w];
        exp_d = ref_mul(eop, w ? a1 : a0, w ? b1 : b0);
        tick();
        lat = 0;
        en_hist = '0;
        for (int k = 1; k <= 12; k++) begin
            en_hist[k] = bus.cell_en;
            if (bus.resp_valid) begin
                lat = k;
                break;
            end
            chk("req_ready_while_busy", bus.req_ready, 0);
            tick();
        end
        if (lat == 0) begin
            chk("resp_valid_timeout", bus.resp_valid, 1);
            bus.req_valid = 2'b00;
            return;
        end
        chk("latency", lat, eop ? 5 : 3);
        chk("cell_en_pattern", en_hist, eop ? 16'h000A : 16'h0002);
        for (int h = 0; h <= hold; h++) begin
            chk("resp_valid_hold", bus.resp_valid, 1);
            chk("resp_data", bus.resp_data, exp_d);
            chk("resp_id", bus.resp_id, w);
            chk("req_ready_in_resp", bus.req_ready, 0);
            if (h == hold) bus.resp_ready = 1'b1;
            tick();
        end
        bus.resp_ready = 1'b0;
        chk("idle_after_handshake", bus.busy, 0);
        chk("resp_valid_after_handshake", bus.resp_valid, 0);
        if (!keep) bus.req_valid = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] vm, ops;
        bus.req_valid  = 2'b00;
        bus.req_op     = 2'b00;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 1'b0;

        // Reset state, both while asserted and once released.
        #1;
        chk_quiet("in_reset");
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk_quiet("after_reset");

        // Directed operand cases.
        serve(2'b01, 2'b00, 32'h0001_0003, 32'h0002_0005, 0, 0, 0, 0);
        serve(2'b10, 2'b10, 0, 0, 32'h0001_0003, 32'h0002_0005, 0, 0);
        serve(2'b01, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0);
        serve(2'b01, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0);

        // Response held off for 10 cycles with a competing request pending.
        serve(2'b11, 2'b01, $urandom, $urandom, $urandom, $urandom, 10, 0);

        // Reset during WAIT1 of a MULXUU aborts it with no response.
        bus.req_valid = 2'b01;
        bus.req_op    = 2'b01;
        bus.req_a     = {32'h0, 32'h1234_5678};
        bus.req_b     = {32'h0, 32'h9ABC_DEF0};
        #1;
        chk("abort_accept", bus.req_ready, 2'b01);
        tick();
        tick();
        chk("abort_in_wait1", bus.busy, 1);
        reset = 1'b1;
        #1;
        chk_quiet("abort_reset");
        bus.req_valid = 2'b00;
        last = 1;
        tick();
        tick();
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("abort_no_resp", bus.resp_valid, 0);
        end

        // Both requesters valid continuously: grants alternate starting with req0.
        for (int t = 0; t < 4; t++)
            serve(2'b11, 2'b00, 32'd7, 32'd9, 32'd6, 32'd4, 0, (t != 3));

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            vm  = 2'($urandom_range(1, 3));
            ops = 2'($urandom_range(0, 3));
            serve(vm, ops, $urandom, $urandom, $urandom, $urandom,
                  $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
